// File: rtl/m68_bus_master.sv
// ---------------------------------------------------------------------------
// m68_bus_master
//
// 68000-style bus initiator. A single-beat valid/ready request is turned into
// an AS/RW/UDS/LDS bus cycle that completes on DTACK. If DTACK never arrives,
// or is never released, a bounded wait returns an error response instead of
// hanging.
//
// Optional feature (compile-time macro M68_BUS_RETRY_EN):
//   defined   - the first DTACK timeout re-runs the same cycle once; only a
//               second timeout reports rsp_err.
//   undefined - the first timeout reports rsp_err; no retry state exists.
//
// Parameters
//   SETUP_CYC    cycles addr/rw/data are stable before AS falls (>=1)
//   TIMEOUT_CYC  max cycles waiting on DTACK in ASSERT, and again in RELEASE (>=4)
//
// Ports
//   clk, rst_n             clock (posedge), asynchronous active-low reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_rw/addr/wdata/be   request fields (rw 1=read, be[1]=UDS, be[0]=LDS,
//                          be 2'b00 treated as 2'b11)
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata/rsp_err      read data (0 on writes/errors), timeout flag
//   M68_addr/data_out/rw   registered bus address, write data, direction
//   M68_as/uds/lds         registered active-low strobes
//   M68_dtack/data_in      responder acknowledge (active-low) and read data
// ---------------------------------------------------------------------------
module m68_bus_master #(
  parameter int SETUP_CYC   = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] M68_addr,
  output logic [15:0] M68_data_out,
  output logic        M68_rw,
  output logic        M68_as,
  output logic        M68_uds,
  output logic        M68_lds,
  input  logic        M68_dtack,
  input  logic [15:0] M68_data_in
);

  // One counter serves SETUP, ASSERT and RELEASE, so size it for the longest.
  localparam int MAX_CYC = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             as_q, as_d;
  logic             uds_q, uds_d;
  logic             lds_q, lds_d;
  logic             rw_q, rw_d;
  logic [23:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0]       be_q, be_d;
  logic             err_pend_q, err_pend_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             retry_now;

`ifdef M68_BUS_RETRY_EN
  // retried_q: the one permitted retry has been used for this request.
  // retry_pend_q: the current RELEASE leads back into SETUP, not to a response.
  logic retried_q, retried_d;
  logic retry_pend_q, retry_pend_d;
  assign retry_now = retry_pend_q;
`else
  assign retry_now = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    as_d        = as_q;
    uds_d       = uds_q;
    lds_d       = lds_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    err_pend_d  = err_pend_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef M68_BUS_RETRY_EN
    retried_d    = retried_q;
    retry_pend_d = retry_pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          // Capture the whole request; the bus sees it from the next cycle
          // while the strobes stay high.
          addr_d      = req_addr;
          rw_d        = req_rw;
          wdata_d     = req_wdata;
          be_d        = (req_be == 2'b00) ? 2'b11 : req_be;
          ready_d     = 1'b0;
          cnt_d       = '0;
          err_pend_d  = 1'b0;
          rsp_rdata_d = 16'h0000;
          rsp_err_d   = 1'b0;
`ifdef M68_BUS_RETRY_EN
          retried_d    = 1'b0;
          retry_pend_d = 1'b0;
`endif
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        // After the setup time, AS is only asserted once DTACK is released,
        // so a responder still finishing a previous cycle cannot ack this one.
        if (cnt_q == SETUP_LAST) begin
          if (M68_dtack) begin
            as_d    = 1'b0;
            uds_d   = ~be_q[1];
            lds_d   = ~be_q[0];
            cnt_d   = '0;
            state_d = S_ASSERT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ASSERT: begin
        if (!M68_dtack) begin
          if (rw_q) rsp_rdata_d = M68_data_in;
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          cnt_d   = '0;
`ifdef M68_BUS_RETRY_EN
          if (!retried_q) begin
            retried_d    = 1'b1;
            retry_pend_d = 1'b1;
          end else begin
            err_pend_d = 1'b1;
          end
`else
          err_pend_d = 1'b1;
`endif
          // A retry also passes through RELEASE: it guarantees DTACK is high
          // and keeps the strobes high for RELEASE + SETUP >= 2 cycles.
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (M68_dtack) begin
          cnt_d = '0;
          if (retry_now) begin
            state_d = S_SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_pend_q;
            if (err_pend_q) rsp_rdata_d = 16'h0000;
            ready_d     = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          // Responder never let go of DTACK: report an error regardless of
          // how the cycle itself ended.
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 16'h0000;
          ready_d     = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef M68_BUS_RETRY_EN
    if (state_q == S_RELEASE && state_d != S_RELEASE) retry_pend_d = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      as_q        <= 1'b1;
      uds_q       <= 1'b1;
      lds_q       <= 1'b1;
      rw_q        <= 1'b1;
      addr_q      <= 24'h000000;
      wdata_q     <= 16'h0000;
      be_q        <= 2'b11;
      err_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
`ifdef M68_BUS_RETRY_EN
      retried_q    <= 1'b0;
      retry_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      as_q        <= as_d;
      uds_q       <= uds_d;
      lds_q       <= lds_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_pend_q  <= err_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef M68_BUS_RETRY_EN
      retried_q    <= retried_d;
      retry_pend_q <= retry_pend_d;
`endif
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign M68_addr     = {8'h00, addr_q};
  assign M68_data_out = wdata_q;
  assign M68_rw       = rw_q;
  assign M68_as       = as_q;
  assign M68_uds      = uds_q;
  assign M68_lds      = lds_q;

endmodule

// File: tb/tb_m68_bus_master.sv
// ---------------------------------------------------------------------------
// tb_m68_bus_master
//
// Self-checking bench: a behavioural 68000 responder (byte-laned word memory
// with configurable DTACK delay / hold / never / stuck behaviour) sits on the
// bus, while a word-level reference memory predicts every response. Bus-side
// observations (AS fall time, lanes, address, data, gaps) are recorded by a
// monitor and compared inside each scenario task.
// ---------------------------------------------------------------------------
module tb_m68_bus_master;
  localparam int SETUP = 1;
  localparam int TMO   = 64;
`ifdef M68_BUS_RETRY_EN
  localparam int ATT = 2;
`else
  localparam int ATT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b1;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = 2'b11;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] M68_addr;
  logic [15:0] M68_data_out;
  logic        M68_rw, M68_as, M68_uds, M68_lds;
  logic        M68_dtack = 1'b1;
  logic [15:0] M68_data_in = '0;

  m68_bus_master #(.SETUP_CYC(SETUP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M68_addr(M68_addr), .M68_data_out(M68_data_out), .M68_rw(M68_rw),
    .M68_as(M68_as), .M68_uds(M68_uds), .M68_lds(M68_lds),
    .M68_dtack(M68_dtack), .M68_data_in(M68_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  // monitor observations
  int          as_falls = 0, fall_cyc = 0, high_run = 0, low_run = 0, last_low_len = 0;
  int          min_gap = 999, fall_dtack_low = 0, strobe_unstable = 0;
  logic [31:0] fall_addr;
  logic        fall_rw, fall_uds, fall_lds;
  logic [15:0] fall_data;
  int          rsp_cnt = 0, rsp_cyc = 0;
  logic [15:0] rsp_rdata_s;
  logic        rsp_err_s;
  logic [15:0] rq_data[$];
  logic        rq_err[$];

  // responder controls: mode 0 normal, 1 never acks, 2 acks then never releases
  int r_k = 1, r_hold = 0, r_mode = 0, r_st = 0, r_low = 0, r_h = 0;
  bit force_low = 1'b0;
  logic [15:0] rmem [int];
  logic [15:0] mmem [int];

  function automatic logic [15:0] init_word(int idx);
    return 16'(idx * 40503) ^ 16'h5A5A;
  endfunction

  // reference memory: word-addressed, UDS lane = bits 15:8
  function automatic logic [15:0] model_read(logic [23:0] a);
    int idx = int'(a[23:1]);
    if (!mmem.exists(idx)) mmem[idx] = init_word(idx);
    return mmem[idx];
  endfunction

  function automatic void model_write(logic [23:0] a, logic [15:0] d, logic [1:0] bee);
    int idx = int'(a[23:1]);
    if (!mmem.exists(idx)) mmem[idx] = init_word(idx);
    if (bee[1]) mmem[idx][15:8] = d[15:8];
    if (bee[0]) mmem[idx][7:0]  = d[7:0];
  endfunction

  always @(negedge clk) begin
    int widx;
    // monitor (uses the DTACK value that was present at the preceding edge)
    if (M68_as == 1'b0) begin
      if (low_run == 0) begin
        as_falls++;
        fall_cyc = cyc;
        if (high_run < min_gap) min_gap = high_run;
        fall_addr = M68_addr; fall_rw = M68_rw; fall_data = M68_data_out;
        fall_uds = M68_uds; fall_lds = M68_lds;
        if (M68_dtack == 1'b0) fall_dtack_low++;
      end else if (M68_uds !== fall_uds || M68_lds !== fall_lds) begin
        strobe_unstable++;
      end
      low_run++; high_run = 0;
    end else begin
      if (low_run != 0) last_low_len = low_run;
      low_run = 0; high_run++;
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_rdata_s = rsp_rdata; rsp_err_s = rsp_err;
      rq_data.push_back(rsp_rdata); rq_err.push_back(rsp_err);
    end
    // responder
    if (!rst_n) begin
      M68_dtack = 1'b1; r_st = 0; r_low = 0;
    end else if (force_low) begin
      M68_dtack = 1'b0; r_st = 0; r_low = 0;
    end else if (r_st == 0) begin
      M68_dtack = 1'b1;
      if (M68_as == 1'b0) begin
        r_low++;
        if (r_mode != 1 && r_low >= r_k) begin
          M68_dtack = 1'b0; r_st = 1; r_h = 0;
          widx = int'(M68_addr[23:1]);
          if (!rmem.exists(widx)) rmem[widx] = init_word(widx);
          if (M68_rw) M68_data_in = rmem[widx];
          else begin
            if (!M68_uds) rmem[widx][15:8] = M68_data_out[15:8];
            if (!M68_lds) rmem[widx][7:0]  = M68_data_out[7:0];
          end
        end
      end else r_low = 0;
    end else if (M68_as == 1'b1 && r_mode != 2) begin
      if (r_h == r_hold) begin M68_dtack = 1'b1; r_st = 0; r_low = 0; end
      else r_h++;
    end
  end

  // stimulus helpers (no comparisons inside)
  task automatic do_req(input logic rw, input logic [23:0] a, input logic [15:0] wd,
                        input logic [1:0] be, output int acc);
    int w = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && w < 300) begin @(negedge clk); #1; w++; end
    req_rw = rw; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (rsp_cnt != start) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", req_ready); end
    n_cmp++; if ({M68_as, M68_uds, M68_lds} !== 3'b111) begin n_bad++; $display("FAIL reset_strobes got %b want 111", {M68_as, M68_uds, M68_lds}); end
    n_cmp++; if (M68_rw !== 1'b1) begin n_bad++; $display("FAIL reset_rw got %b want 1", M68_rw); end
    n_cmp++; if (M68_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", M68_addr); end
    n_cmp++; if (M68_data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data_out got %h want 0", M68_data_out); end
    n_cmp++; if ({rsp_valid, rsp_err} !== 2'b00) begin n_bad++; $display("FAIL reset_rsp got %b want 00", {rsp_valid, rsp_err}); end
    n_cmp++; if (rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1 || M68_as !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle got ready=%b as=%b want 1 1", req_ready, M68_as); end
  endtask

  task automatic test_read_fixed;
    int acc, r0; bit got;
    rmem[int'(24'hC00004 >> 1)] = 16'h3400; mmem[int'(24'hC00004 >> 1)] = 16'h3400;
    r_mode = 0; r_k = 2; r_hold = 0; r0 = rsp_cnt;
    do_req(1'b1, 24'hC00004, 16'h0, 2'b11, acc);
    wait_rsp(r0, 200, got);
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (!got || rsp_cnt - r0 != 1) begin n_bad++; $display("FAIL rd_rsp_count got %0d want 1", rsp_cnt - r0); end
    n_cmp++; if (rsp_rdata_s !== 16'h3400) begin n_bad++; $display("FAIL rd_data got %h want 3400", rsp_rdata_s); end
    n_cmp++; if (rsp_err_s !== 1'b0) begin n_bad++; $display("FAIL rd_err got %b want 0", rsp_err_s); end
    n_cmp++; if (fall_rw !== 1'b1) begin n_bad++; $display("FAIL rd_rw got %b want 1", fall_rw); end
    n_cmp++; if ({fall_uds, fall_lds} !== 2'b00) begin n_bad++; $display("FAIL rd_lanes got %b want 00", {fall_uds, fall_lds}); end
    n_cmp++; if (rsp_cyc - acc + 1 != SETUP + 2 + 2) begin n_bad++; $display("FAIL rd_latency got %0d want %0d", rsp_cyc - acc + 1, SETUP + 4); end
  endtask

  task automatic test_write_fixed;
    int acc, r0; bit got;
    r_mode = 0; r_k = 1; r_hold = 1; r0 = rsp_cnt;
    model_write(24'hC00000, 16'h8144, 2'b11);
    do_req(1'b0, 24'hC00000, 16'h8144, 2'b11, acc);
    wait_rsp(r0, 200, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL wr_rsp got none want 1"); end
    n_cmp++; if (fall_data !== 16'h8144 || fall_rw !== 1'b0) begin n_bad++; $display("FAIL wr_bus got data=%h rw=%b want 8144 0", fall_data, fall_rw); end
    n_cmp++; if (fall_cyc - acc != SETUP) begin n_bad++; $display("FAIL wr_setup got %0d want %0d", fall_cyc - acc, SETUP); end
    n_cmp++; if (rsp_rdata_s !== 16'h0 || rsp_err_s !== 1'b0) begin n_bad++; $display("FAIL wr_rsp_fields got %h/%b want 0/0", rsp_rdata_s, rsp_err_s); end
    n_cmp++; if (rmem[int'(24'hC00000 >> 1)] !== mmem[int'(24'hC00000 >> 1)]) begin n_bad++; $display("FAIL wr_mem got %h want %h", rmem[int'(24'hC00000 >> 1)], mmem[int'(24'hC00000 >> 1)]); end
  endtask

  task automatic test_byte_lanes;
    int acc, r0, u0; bit got;
    logic [1:0] bes [2];
    bes[0] = 2'b01; bes[1] = 2'b00;
    r_mode = 0; r_k = 3; r_hold = 0;
    for (int i = 0; i < 2; i++) begin
      r0 = rsp_cnt; u0 = strobe_unstable;
      model_write(24'h001001, 16'hA55A + 16'(i), (bes[i] == 2'b00) ? 2'b11 : bes[i]);
      do_req(1'b0, 24'h001001, 16'hA55A + 16'(i), bes[i], acc);
      wait_rsp(r0, 200, got);
      n_cmp++; if (!got) begin n_bad++; $display("FAIL lane_rsp be=%b got none", bes[i]); end
      n_cmp++; if ({fall_uds, fall_lds} !== ((i == 0) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL lane_strobes be=%b got %b want %b", bes[i], {fall_uds, fall_lds}, (i == 0) ? 2'b10 : 2'b00); end
      n_cmp++; if (strobe_unstable != u0) begin n_bad++; $display("FAIL lane_stable be=%b got %0d changes want 0", bes[i], strobe_unstable - u0); end
      n_cmp++; if (rmem[int'(24'h001001 >> 1)] !== mmem[int'(24'h001001 >> 1)]) begin n_bad++; $display("FAIL lane_mem be=%b got %h want %h", bes[i], rmem[int'(24'h001001 >> 1)], mmem[int'(24'h001001 >> 1)]); end
    end
  endtask

  task automatic test_random;
    int acc, r0, u0, k, h; bit got;
    logic rw; logic [23:0] a; logic [15:0] wd, exp; logic [1:0] be, bee;
    r_mode = 0;
    for (int t = 0; t < 30; t++) begin
      k = int'($urandom_range(1, 5)); h = int'($urandom_range(0, 3));
      rw = 1'($urandom); a = 24'h000100 + 24'($urandom_range(0, 31));
      wd = 16'($urandom); be = 2'($urandom);
      bee = (be == 2'b00) ? 2'b11 : be;
      if (rw) exp = model_read(a);
      else begin model_write(a, wd, bee); exp = 16'h0; end
      r_k = k; r_hold = h; r0 = rsp_cnt; u0 = strobe_unstable;
      do_req(rw, a, wd, be, acc);
      wait_rsp(r0, 200, got);
      repeat (2) @(negedge clk); #1;
      n_cmp++; if (!got || rsp_cnt - r0 != 1) begin n_bad++; $display("FAIL rnd%0d_count got %0d want 1", t, rsp_cnt - r0); end
      n_cmp++; if (rsp_rdata_s !== exp) begin n_bad++; $display("FAIL rnd%0d_rdata got %h want %h", t, rsp_rdata_s, exp); end
      n_cmp++; if (rsp_err_s !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_err got %b want 0", t, rsp_err_s); end
      n_cmp++; if (rsp_cyc - acc + 1 != SETUP + k + 2 + h) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", t, rsp_cyc - acc + 1, SETUP + k + 2 + h); end
      n_cmp++; if (fall_cyc - acc != SETUP) begin n_bad++; $display("FAIL rnd%0d_setup got %0d want %0d", t, fall_cyc - acc, SETUP); end
      n_cmp++; if (fall_addr !== {8'h00, a} || fall_rw !== rw) begin n_bad++; $display("FAIL rnd%0d_addr got %h/%b want %h/%b", t, fall_addr, fall_rw, {8'h00, a}, rw); end
      if (!rw) begin
        n_cmp++; if (fall_data !== wd) begin n_bad++; $display("FAIL rnd%0d_wdata got %h want %h", t, fall_data, wd); end
      end
      n_cmp++; if ({fall_uds, fall_lds} !== ~bee) begin n_bad++; $display("FAIL rnd%0d_lanes got %b want %b", t, {fall_uds, fall_lds}, ~bee); end
      n_cmp++; if (strobe_unstable != u0) begin n_bad++; $display("FAIL rnd%0d_stable got %0d changes want 0", t, strobe_unstable - u0); end
    end
  endtask

  task automatic test_timeout;
    int acc, r0, f0; bit got;
    r_mode = 1; r0 = rsp_cnt; f0 = as_falls; min_gap = 999;
    do_req(1'b1, 24'h000104, 16'h0, 2'b11, acc);
    wait_rsp(r0, 400, got);
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (!got || rsp_cnt - r0 != 1) begin n_bad++; $display("FAIL to_count got %0d want 1", rsp_cnt - r0); end
    n_cmp++; if (rsp_err_s !== 1'b1 || rsp_rdata_s !== 16'h0) begin n_bad++; $display("FAIL to_rsp got err=%b rdata=%h want 1 0", rsp_err_s, rsp_rdata_s); end
    n_cmp++; if (as_falls - f0 != ATT) begin n_bad++; $display("FAIL to_attempts got %0d want %0d", as_falls - f0, ATT); end
    n_cmp++; if (last_low_len != TMO) begin n_bad++; $display("FAIL to_as_len got %0d want %0d", last_low_len, TMO); end
    n_cmp++; if (rsp_cyc - acc < ATT * TMO) begin n_bad++; $display("FAIL to_early got %0d want >=%0d", rsp_cyc - acc, ATT * TMO); end
    if (ATT == 2) begin
      n_cmp++; if (min_gap < 2) begin n_bad++; $display("FAIL to_retry_gap got %0d want >=2", min_gap); end
    end
    r_mode = 0;
  endtask

  task automatic test_release_timeout;
    int acc, r0, f0, rel; bit got;
    r_mode = 2; r_k = 1; r0 = rsp_cnt;
    do_req(1'b1, 24'hC00004, 16'h0, 2'b11, acc);
    wait_rsp(r0, 400, got);
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rel_to_rsp got none want 1"); end
    n_cmp++; if (rsp_err_s !== 1'b1 || rsp_rdata_s !== 16'h0) begin n_bad++; $display("FAIL rel_to_fields got err=%b rdata=%h want 1 0", rsp_err_s, rsp_rdata_s); end
    // DTACK still low at the next accept: AS must wait for its release
    force_low = 1'b1; r_mode = 0; r_k = 1; r_hold = 0;
    r0 = rsp_cnt; f0 = as_falls;
    model_write(24'h000200, 16'h1234, 2'b11);
    do_req(1'b0, 24'h000200, 16'h1234, 2'b11, acc);
    repeat (5) @(negedge clk); #1;
    n_cmp++; if (as_falls != f0 || M68_as !== 1'b1) begin n_bad++; $display("FAIL stretch_hold got falls=%0d as=%b want 0 1", as_falls - f0, M68_as); end
    force_low = 1'b0; rel = cyc;
    wait_rsp(r0, 200, got);
    n_cmp++; if (fall_cyc != rel + 2) begin n_bad++; $display("FAIL stretch_fall got %0d want %0d", fall_cyc, rel + 2); end
    n_cmp++; if (!got || rsp_err_s !== 1'b0) begin n_bad++; $display("FAIL stretch_rsp got got=%b err=%b want 1 0", got, rsp_err_s); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] eq_d[$];
    logic rw; logic [23:0] a; logic [15:0] wd; logic [1:0] be;
    int w, d0;
    rq_data.delete(); rq_err.delete();
    r_mode = 0; r_k = 2; r_hold = 2; min_gap = 999; d0 = fall_dtack_low;
    @(negedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      rw = (i % 2 == 1); a = 24'h000300 + 24'(2 * (i / 2)); wd = 16'($urandom); be = 2'($urandom);
      if (rw) eq_d.push_back(model_read(a));
      else begin model_write(a, wd, (be == 2'b00) ? 2'b11 : be); eq_d.push_back(16'h0); end
      req_rw = rw; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
      w = 0;
      while (req_ready !== 1'b1 && w < 300) begin @(negedge clk); #1; w++; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    w = 0;
    while (rq_data.size() < 6 && w < 300) begin @(negedge clk); #1; w++; end
    n_cmp++; if (rq_data.size() != 6) begin n_bad++; $display("FAIL b2b_count got %0d want 6", rq_data.size()); end
    for (int i = 0; i < 6 && i < rq_data.size(); i++) begin
      n_cmp++; if (rq_data[i] !== eq_d[i] || rq_err[i] !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp%0d got %h/%b want %h/0", i, rq_data[i], rq_err[i], eq_d[i]); end
    end
    n_cmp++; if (min_gap < 2) begin n_bad++; $display("FAIL b2b_gap got %0d want >=2", min_gap); end
    n_cmp++; if (fall_dtack_low != d0) begin n_bad++; $display("FAIL b2b_dtack_release got %0d early falls want 0", fall_dtack_low - d0); end
  endtask

  task automatic test_reset_midcycle;
    int acc, r0, w; bit low;
    r_mode = 1; r0 = rsp_cnt;
    do_req(1'b1, 24'h000110, 16'h0, 2'b11, acc);
    low = 1'b0;
    for (w = 0; w < 50; w++) begin @(negedge clk); #1; if (M68_as === 1'b0) begin low = 1'b1; break; end end
    n_cmp++; if (!low) begin n_bad++; $display("FAIL mid_as_low got as=%b want 0", M68_as); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({M68_as, M68_uds, M68_lds} !== 3'b111 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_strobes got %b rsp=%b want 111 0", {M68_as, M68_uds, M68_lds}, rsp_valid); end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1; r_mode = 0;
    repeat (10) @(negedge clk); #1;
    n_cmp++; if (rsp_cnt != r0) begin n_bad++; $display("FAIL mid_no_rsp got %0d pulses want 0", rsp_cnt - r0); end
    n_cmp++; if (req_ready !== 1'b1 || M68_as !== 1'b1) begin n_bad++; $display("FAIL mid_idle got ready=%b as=%b want 1 1", req_ready, M68_as); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_fixed();
    test_write_fixed();
    test_byte_lanes();
    test_random();
    test_timeout();
    test_release_timeout();
    test_back_to_back();
    test_reset_midcycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
